// File: rtl/disp_scroll_ctrl.sv
// Message sequencer for a 4-digit seven-segment multiplexer: buffers segment patterns and
// scrolls a 4-digit window across them. Optional blinking with DISP_SCROLL_CTRL_BLINK_EN.
module disp_scroll_ctrl #(
  parameter int unsigned DEPTH     = 16,
  parameter int unsigned STEP_DIV  = 12_500_000,
  parameter int unsigned BLINK_DIV = 25_000_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       wr_en,
  input  logic [7:0] wr_data,
  output logic       wr_ready,
  input  logic       clr,
  input  logic       start,
  input  logic       loop,
  input  logic       stop,
`ifdef DISP_SCROLL_CTRL_BLINK_EN
  input  logic       blink,
`endif
  output logic       busy,
  output logic       done,
  output logic [7:0] dig3,
  output logic [7:0] dig2,
  output logic [7:0] dig1,
  output logic [7:0] dig0
);

  localparam int unsigned AddrW = $clog2(DEPTH);
  localparam int unsigned LenW  = AddrW + 1;
  localparam int unsigned PosW  = $clog2(DEPTH + 4);
  localparam int unsigned CntW  = $clog2(STEP_DIV);

  typedef enum logic [0:0] {StIdle, StScroll} state_e;

  state_e          state_q, state_d;
  logic [LenW-1:0] len_q, len_d;
  logic [PosW-1:0] pos_q, pos_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            loop_q, loop_d;
  logic            done_q, done_d;
  logic            wr_fire;
  logic            blank_d;
  logic [7:0]      buf_q [DEPTH];
  logic [7:0]      dig_q [4];
  logic [7:0]      dig_d [4];

  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    pos_d   = pos_q;
    cnt_d   = cnt_q;
    loop_d  = loop_q;
    done_d  = 1'b0;
    wr_fire = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (clr) begin
          len_d = '0;
        end else if (wr_en && (len_q < LenW'(DEPTH))) begin
          wr_fire = 1'b1;
          len_d   = len_q + 1'b1;
        end
        // Start sees the post-write length so a same-cycle write is scrolled too.
        if (start && !stop && (len_d != '0)) begin
          state_d = StScroll;
          pos_d   = '0;
          cnt_d   = '0;
          loop_d  = loop;
        end
      end
      StScroll: begin
        if (stop) begin
          state_d = StIdle;
          pos_d   = '0;
          cnt_d   = '0;
        end else if (cnt_q == CntW'(STEP_DIV - 1)) begin
          cnt_d = '0;
          if (pos_q < PosW'(len_q)) begin
            pos_d = pos_q + 1'b1;
          end else if (loop_q) begin
            pos_d = '0;
          end else begin
            done_d  = 1'b1;
            state_d = StIdle;
            pos_d   = '0;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Window is built from next-state values so digits change on the same edge as pos.
  always_comb begin
    for (int k = 0; k < 4; k++) begin
      dig_d[k] = 8'hFF;
      if ((state_d == StScroll) && !blank_d && ((int'(pos_d) + k) < int'(len_d))) begin
        if (wr_fire && ((int'(pos_d) + k) == int'(len_q))) begin
          dig_d[k] = wr_data;
        end else begin
          dig_d[k] = buf_q[AddrW'(int'(pos_d) + k)];
        end
      end
    end
  end

`ifdef DISP_SCROLL_CTRL_BLINK_EN
  localparam int unsigned BlkW = $clog2(BLINK_DIV);

  logic [BlkW-1:0] bcnt_q, bcnt_d;
  logic            phase_q, phase_d;

  always_comb begin
    bcnt_d  = bcnt_q;
    phase_d = phase_q;
    if (state_q == StIdle) begin
      bcnt_d  = '0;
      phase_d = 1'b0;
    end else if (bcnt_q == BlkW'(BLINK_DIV - 1)) begin
      bcnt_d  = '0;
      phase_d = ~phase_q;
    end else begin
      bcnt_d = bcnt_q + 1'b1;
    end
    blank_d = blink & phase_d;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      bcnt_q  <= '0;
      phase_q <= 1'b0;
    end else begin
      bcnt_q  <= bcnt_d;
      phase_q <= phase_d;
    end
  end
`else
  assign blank_d = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      len_q   <= '0;
      pos_q   <= '0;
      cnt_q   <= '0;
      loop_q  <= 1'b0;
      done_q  <= 1'b0;
      for (int k = 0; k < 4; k++) dig_q[k] <= 8'hFF;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      pos_q   <= pos_d;
      cnt_q   <= cnt_d;
      loop_q  <= loop_d;
      done_q  <= done_d;
      for (int k = 0; k < 4; k++) dig_q[k] <= dig_d[k];
    end
  end

  // Message RAM is deliberately not reset.
  always_ff @(posedge clk) begin
    if (!reset && wr_fire) buf_q[len_q[AddrW-1:0]] <= wr_data;
  end

  assign wr_ready = (state_q == StIdle);
  assign busy     = (state_q == StScroll);
  assign done     = done_q;
  assign dig3     = dig_q[0];
  assign dig2     = dig_q[1];
  assign dig1     = dig_q[2];
  assign dig0     = dig_q[3];

endmodule

// File: tb/tb_disp_scroll_ctrl.sv
// Bench for disp_scroll_ctrl: directed scenarios then random traffic, all checked every cycle
// against a cycle-count based model of the scrolling message.
module tb_disp_scroll_ctrl;

  localparam int unsigned Depth    = 16;
  localparam int unsigned StepDiv  = 4;
  localparam int unsigned BlinkDiv = 2;

  logic       clk = 1'b0;
  logic       reset, wr_en, clr, start, loop, stop, blink;
  logic [7:0] wr_data;
  logic       wr_ready, busy, done;
  logic [7:0] dig3, dig2, dig1, dig0;

  int n_checks = 0;
  int n_fail   = 0;

  // Model: message contents, length and cycles elapsed since start.
  logic [7:0] m_buf [Depth];
  int         m_len  = 0;
  int         m_t    = 0;
  bit         m_busy = 1'b0;
  bit         m_done = 1'b0;
  bit         m_loop = 1'b0;

  disp_scroll_ctrl #(
    .DEPTH    (Depth),
    .STEP_DIV (StepDiv),
    .BLINK_DIV(BlinkDiv)
  ) u_dut (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (wr_en),
    .wr_data (wr_data),
    .wr_ready(wr_ready),
    .clr     (clr),
    .start   (start),
    .loop    (loop),
    .stop    (stop),
`ifdef DISP_SCROLL_CTRL_BLINK_EN
    .blink   (blink),
`endif
    .busy    (busy),
    .done    (done),
    .dig3    (dig3),
    .dig2    (dig2),
    .dig1    (dig1),
    .dig0    (dig0)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [7:0] vstream(input int i);
    return (i < m_len) ? m_buf[i] : 8'hFF;
  endfunction

  function automatic logic [31:0] exp_digits();
    int step, pos;
    if (!m_busy) return 32'hFFFF_FFFF;
`ifdef DISP_SCROLL_CTRL_BLINK_EN
    if (blink && (((m_t / BlinkDiv) % 2) == 1)) return 32'hFFFF_FFFF;
`endif
    step = m_t / StepDiv;
    pos  = m_loop ? (step % (m_len + 1)) : step;
    return {vstream(pos), vstream(pos + 1), vstream(pos + 2), vstream(pos + 3)};
  endfunction

  // Advance the model on the current inputs, clock once, compare, then drop pulse inputs.
  task automatic cyc();
    m_done = 1'b0;
    if (reset) begin
      m_busy = 1'b0;
      m_len  = 0;
    end else if (!m_busy) begin
      if (clr) m_len = 0;
      else if (wr_en && m_len < Depth) begin
        m_buf[m_len] = wr_data;
        m_len++;
      end
      if (start && !stop && m_len > 0) begin
        m_busy = 1'b1;
        m_t    = 0;
        m_loop = loop;
      end
    end else if (stop) begin
      m_busy = 1'b0;
    end else begin
      m_t++;
      if (!m_loop && m_t == (m_len + 1) * StepDiv) begin
        m_busy = 1'b0;
        m_done = 1'b1;
      end
    end
    @(posedge clk);
    #1;
    check_eq("digits", {dig3, dig2, dig1, dig0}, exp_digits());
    check_eq("busy", 32'(busy), 32'(m_busy));
    check_eq("done", 32'(done), 32'(m_done));
    check_eq("wr_ready", 32'(wr_ready), 32'(!m_busy));
    reset = 1'b0;
    wr_en = 1'b0;
    clr   = 1'b0;
    start = 1'b0;
    stop  = 1'b0;
  endtask

  task automatic write_byte(input logic [7:0] d);
    wr_en   = 1'b1;
    wr_data = d;
    cyc();
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cyc();
  endtask

  initial begin
    reset = 1'b1; wr_en = 1'b0; clr = 1'b0; start = 1'b0; loop = 1'b0; stop = 1'b0;
    blink = 1'b0; wr_data = 8'h00;
    cyc();

    // Reset while scrolling.
    write_byte(8'hA1); write_byte(8'hA2);
    start = 1'b1; cyc();
    run(5);
    reset = 1'b1; cyc();
    start = 1'b1; cyc();          // len is 0 after reset: must stay idle
    run(2);

    // Single pass over three patterns.
    write_byte(8'h01); write_byte(8'h02); write_byte(8'h03);
    loop = 1'b0; start = 1'b1; cyc();
    run(18);

    // Overflow: 17th write is dropped, buf[15] = 8'h1F.
    clr = 1'b1; cyc();
    for (int i = 0; i < 17; i++) write_byte(8'(8'h10 + i));
    start = 1'b1; cyc();
    run(70);

    // Loop over two patterns, then stop mid-step.
    clr = 1'b1; cyc();
    write_byte(8'h55); write_byte(8'h66);
    loop = 1'b1; start = 1'b1; cyc();
    run(30);
    stop = 1'b1; cyc();
    run(3);

    // Corner cases: clr beats wr_en, stop beats start, write+start together.
    clr = 1'b1; cyc();
    start = 1'b1; cyc();
    clr = 1'b1; wr_en = 1'b1; wr_data = 8'h99; cyc();
    wr_en = 1'b1; wr_data = 8'h42; start = 1'b1; stop = 1'b1; cyc();
    clr = 1'b1; cyc();
    loop = 1'b0; wr_en = 1'b1; wr_data = 8'h77; start = 1'b1; cyc();
    run(10);

`ifdef DISP_SCROLL_CTRL_BLINK_EN
    clr = 1'b1; cyc();
    write_byte(8'h0A); write_byte(8'h0B); write_byte(8'h0C);
    blink = 1'b1; loop = 1'b1; start = 1'b1; cyc();
    run(20);
    stop = 1'b1; cyc();
    blink = 1'b0;
`endif

    // Random traffic.
    for (int i = 0; i < 20000; i++) begin
      reset   = ($urandom_range(0, 255) == 0);
      wr_en   = ($urandom_range(0, 9) < 3);
      wr_data = 8'($urandom);
      clr     = ($urandom_range(0, 39) == 0);
      start   = ($urandom_range(0, 9) == 0);
      stop    = ($urandom_range(0, 199) == 0);
      if (start) loop = ($urandom_range(0, 3) == 0);
`ifdef DISP_SCROLL_CTRL_BLINK_EN
      if ($urandom_range(0, 15) == 0) blink = ~blink;
`endif
      cyc();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
